stream_fifo: RTL and testbench
==============================

// Module: stream_fifo
//
// PURPOSE
// Parametrised valid/ready stream buffer between two stream endpoints whose
// fields mirror the stream interface (data, valid, ready). It decouples a
// producer from a consumer with DEPTH entries of storage. It is the sequential
// successor to the plain interface pass-through: it adds configurable width
// and depth, backpressure, and an optional zero-latency fall-through path.
//
// PARAMETERS
// DATA_WIDTH  32  width of in_data/out_data in bits (>=1)
// DEPTH       4   number of storage entries (>=2; need not be a power of two)
// CW          $clog2(DEPTH+1)  derived (localparam): width of level
//
// PORTS
// clk        in   1           single clock, all state updates on rising edge
// rst_ni     in   1           reset, synchronous, active-low
// in_data    in   DATA_WIDTH  producer data
// in_valid   in   1           producer offers in_data
// in_ready   out  1           buffer accepts in_data this cycle
// out_data   out  DATA_WIDTH  head-of-queue data
// out_valid  out  1           out_data is valid
// out_ready  in   1           consumer takes out_data this cycle
// level      out  CW          number of entries currently stored
//
// BEHAVIOUR
// - Push = in_valid & in_ready; pop = out_valid & out_ready; both at posedge.
// - Storage: circular array mem[DEPTH], wr_ptr/rd_ptr wrap from DEPTH-1 to 0
//   (explicit compare, not modulo power of two); count register = level.
// - in_ready  = rst_ni & (count != DEPTH). Full blocks push even if pop occurs
//   in the same cycle (no ready pass-through; ready never depends on out_ready).
// - out_valid = (count != 0); out_data = out_valid ? mem[rd_ptr] : '0.
// - Latency: a word pushed into an empty buffer appears at out_valid one
//   cycle later (macro off).
// - Simultaneous push and pop with 0<count<DEPTH: both pointers advance, count
//   unchanged. Push only: count+1. Pop only: count-1.
// - Data order strictly FIFO; no word is dropped or duplicated.
// - Once out_valid is high, out_valid and out_data stay stable until popped.
// - Reset: while rst_ni==0 at a clock edge, wr_ptr, rd_ptr and count are
//   cleared to 0. mem is not reset. Outputs after reset: in_ready=1,
//   out_valid=0, out_data=0, level=0. While rst_ni is low, in_ready=0.
// - Reset mid-operation discards all stored words; no pop is reported for
//   them.
//
// CONFIGURATION
// STREAM_FIFO_FALLTHROUGH_EN defined:
//   - When count==0, out_valid = in_valid and out_data = in_data in the same
//     cycle (combinational).
//   - If out_ready is also 1, the word bypasses storage: count and the
//     pointers are unchanged. Otherwise it is written as a normal push.
//   - in_ready is unchanged by the macro. With rst_ni low, out_valid=0.
// STREAM_FIFO_FALLTHROUGH_EN undefined: no combinational in->out path.
//   Minimum latency is 1 cycle, as described above.
//
// TESTING
// 1. Reset with in_valid=1 -> in_ready=0 during reset. After release:
//    in_ready=1, out_valid=0, level=0, out_data=0.
// 2. DEPTH=4: push 0xA0..0xA3 with out_ready=0 -> level=4, in_ready=0.
//    A 5th push is refused. Then pop 4 -> 0xA0,0xA1,0xA2,0xA3 in order.
// 3. DEPTH=3, continuous push and pop for 10 words (pointer wrap at 2->0)
//    -> output sequence equals input sequence; level stays 1.
// 4. Full and both valids high -> pop occurs, push refused, level 4->3,
//    in_ready=1 next cycle.
// 5. Reset asserted with level=3 -> next cycle level=0, out_valid=0.
//    Pushing 0x55 afterwards yields 0x55 first.
// 6. FALLTHROUGH_EN, empty, in_valid=1, in_data=0x77, out_ready=1 ->
//    out_valid=1 and out_data=0x77 in the same cycle, level stays 0.
//    Same with out_ready=0 -> level=1 next cycle.

Source files
------------

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready stream buffer; optional fall-through via STREAM_FIFO_FALLTHROUGH_EN
module stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         level
);

    // Pointer width; DEPTH >= 2 keeps this at least one bit.
    localparam int PW = $clog2(DEPTH);

    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic                  full;
    logic                  stored_valid;
    logic                  bypass;
    logic                  push;
    logic                  pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == LAST_IDX) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign full         = (count == FULL_CNT);
    assign stored_valid = (count != '0);

    // Ready depends only on occupancy, never on the consumer side.
    assign in_ready = rst_ni & ~full;

`ifdef STREAM_FIFO_FALLTHROUGH_EN
    // An empty buffer presents the producer word directly; if the consumer
    // takes it in the same cycle the word never touches storage.
    assign bypass = rst_ni & ~stored_valid & in_valid & out_ready;

    // Head-of-queue selection: stored word first, else the live input word.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        if (stored_valid) begin
            out_valid = 1'b1;
            out_data  = mem[rd_ptr];
        end else if (rst_ni && in_valid) begin
            out_valid = 1'b1;
            out_data  = in_data;
        end
    end
`else
    assign bypass = 1'b0;

    // Head-of-queue selection: only stored words are ever presented.
    always_comb begin
        out_valid = stored_valid;
        out_data  = '0;
        if (stored_valid) begin
            out_data = mem[rd_ptr];
        end
    end
`endif

    assign push  = in_valid & in_ready & ~bypass;
    assign pop   = stored_valid & out_ready;
    assign level = count;

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - directed self-checking bench for stream_fifo (DEPTH 4 and 3)
module tb_stream_fifo;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] a_in_data;
    logic       a_in_valid;
    logic       a_in_ready;
    logic [7:0] a_out_data;
    logic       a_out_valid;
    logic       a_out_ready;
    logic [2:0] a_level;

    logic [7:0] b_in_data;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [7:0] b_out_data;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [1:0] b_level;

    int         n_total = 0;
    int         n_pass  = 0;

    always #5 clk = ~clk;

    stream_fifo #(.DATA_WIDTH(8), .DEPTH(4)) u_a (
        .clk       (clk),
        .rst_ni    (rst_n),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .level     (a_level)
    );

    stream_fifo #(.DATA_WIDTH(8), .DEPTH(3)) u_b (
        .clk       (clk),
        .rst_ni    (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .level     (b_level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h11;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = 8'h00;
        b_out_ready = 1'b0;

        // reset with a producer already offering data
        tick();
        check("rst_in_ready", a_in_ready, 0);
        tick();
        check("rst_in_ready2", a_in_ready, 0);
        rst_n      = 1'b1;
        a_in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", a_in_ready, 1);
        check("post_rst_out_valid", a_out_valid, 0);
        check("post_rst_level", a_level, 0);
        check("post_rst_out_data", a_out_data, 0);
        check("post_rst_b_level", b_level, 0);

        // fill DEPTH=4 with 0xA0..0xA3, consumer stalled
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'hA0 + 8'(i);
            tick();
            check("fill_level", a_level, i + 1);
            check("fill_out_valid", a_out_valid, 1);
        end
        a_in_data = 8'hA4;
        #1;
        check("full_in_ready", a_in_ready, 0);
        check("full_level", a_level, 4);
        tick();
        check("refused_level", a_level, 4);
        check("stable_head", a_out_data, 8'hA0);

        // drain in order
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", a_out_valid, 1);
            check("drain_data", a_out_data, 8'hA0 + i);
            tick();
        end
        check("drained_level", a_level, 0);
        check("drained_valid", a_out_valid, 0);
        check("drained_data", a_out_data, 0);

        // DEPTH=3 continuous streaming across pointer wraps
        b_in_valid  = 1'b1;
        b_in_data   = 8'hD0;
        b_out_ready = 1'b0;
        tick();
        check("stream_prime_level", b_level, 1);
        for (int k = 1; k < 10; k++) begin
            b_in_data   = 8'hD0 + 8'(k);
            b_out_ready = 1'b1;
            #1;
            check("stream_data", b_out_data, 8'hD0 + k - 1);
            check("stream_in_ready", b_in_ready, 1);
            tick();
            check("stream_level", b_level, 1);
        end
        b_in_valid = 1'b0;
        #1;
        check("stream_last", b_out_data, 8'hD9);
        tick();
        check("stream_end_level", b_level, 0);
        b_out_ready = 1'b0;

        // full with both sides active: pop only
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'hB0 + 8'(i);
            tick();
        end
        check("t4_level_full", a_level, 4);
        a_in_data   = 8'hBF;
        a_out_ready = 1'b1;
        #1;
        check("t4_in_ready", a_in_ready, 0);
        check("t4_head", a_out_data, 8'hB0);
        tick();
        check("t4_level", a_level, 3);
        check("t4_in_ready_next", a_in_ready, 1);
        a_in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            check("t4_drain", a_out_data, 8'hB0 + i);
            tick();
        end
        check("t4_empty", a_level, 0);

        // reset mid-operation discards stored words
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'hC0 + 8'(i);
            tick();
        end
        check("t5_level3", a_level, 3);
        a_in_valid = 1'b0;
        rst_n      = 1'b0;
        tick();
        check("t5_level", a_level, 0);
        check("t5_out_valid", a_out_valid, 0);
        check("t5_in_ready_rst", a_in_ready, 0);
        rst_n      = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = 8'h55;
        tick();
        a_in_valid = 1'b0;
        #1;
        check("t5_first_valid", a_out_valid, 1);
        check("t5_first_data", a_out_data, 8'h55);
        check("t5_first_level", a_level, 1);
        a_out_ready = 1'b1;
        tick();
        check("t5_popped", a_level, 0);

`ifdef STREAM_FIFO_FALLTHROUGH_EN
        // fall-through: same-cycle visibility, bypass when consumed
        a_in_valid  = 1'b1;
        a_in_data   = 8'h77;
        a_out_ready = 1'b1;
        #1;
        check("ft_out_valid", a_out_valid, 1);
        check("ft_out_data", a_out_data, 8'h77);
        tick();
        check("ft_bypass_level", a_level, 0);
        a_out_ready = 1'b0;
        #1;
        check("ft_stall_valid", a_out_valid, 1);
        tick();
        check("ft_stall_level", a_level, 1);
`else
        // no combinational path: word appears one cycle after the push
        a_in_valid  = 1'b1;
        a_in_data   = 8'h77;
        a_out_ready = 1'b1;
        #1;
        check("noft_out_valid", a_out_valid, 0);
        check("noft_out_data", a_out_data, 0);
        tick();
        a_in_valid = 1'b0;
        #1;
        check("noft_level", a_level, 1);
        check("noft_data_next", a_out_data, 8'h77);
        tick();
        check("noft_popped", a_level, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
